// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encoding, ACK/NACK bus levels and
// the position of the R/W flag inside the address byte.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_ADDR,
    ST_REG,
    ST_ACK_REG,
    ST_WDATA,
    ST_ACK_W,
    ST_RDATA,
    ST_ACK_R,
    ST_IGNORE
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam int   RW_BIT   = 0;

endpackage

// File: rtl/i2c_pin_sync.sv
// SCL/SDA 2-FF synchronizer plus edge, START and STOP detection.
// Strobes are registered: 3 clk from pin edge to strobe.
module i2c_pin_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [2:0] scl_q;
  logic [2:0] sda_q;
  logic       scl_rise_q, scl_fall_q, start_q, stop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q      <= 3'b111;
      sda_q      <= 3'b111;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_q      <= {scl_q[1:0], scl_i};
      sda_q      <= {sda_q[1:0], sda_i};
      scl_rise_q <= scl_q[1] & ~scl_q[2];
      scl_fall_q <= ~scl_q[1] & scl_q[2];
      // SDA edges only count as START/STOP while SCL is stable high
      start_q    <= scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
      stop_q     <= scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
    end
  end

  assign sda_o      = sda_q[2];
  assign scl_rise_o = scl_rise_q;
  assign scl_fall_o = scl_fall_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;

endmodule

// File: rtl/i2c_reg_responder.sv
// I2C register target: byte-wide register file behind a 7-bit address, SDA open-drain.
// SDA changes one cycle after a synchronized SCL fall; wr_valid one cycle after the 8th data bit.
module i2c_reg_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = 7'h76,
  parameter int         REG_DEPTH = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       busy,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data
);

  localparam int IDX_W = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_pin_sync u_pin_sync (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (scl_in),
    .sda_i      (sda_in),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  i2c_state_e       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             rw_q, rw_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             sda_oe_q, sda_oe_d;
  logic             busy_q, busy_d;
  logic             ack_hi_q, ack_hi_d;
  logic             wr_valid_q, wr_valid_d;
  logic [7:0]       wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic [7:0]       dbg_data_q;
  logic [7:0]       regs_q [REG_DEPTH];

  logic       reg_we;
  logic [7:0] rx_byte, rd_byte, ptr8;
  logic       last_bit;

  always_comb begin
    ptr8             = '0;
    ptr8[IDX_W-1:0]  = ptr_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    ack_hi_d   = ack_hi_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    reg_we     = 1'b0;
    rx_byte    = {shift_q[6:0], sda_s};
    rd_byte    = regs_q[ptr_q];
    last_bit   = (cnt_q == 3'd7);

    // START/STOP take priority over any bit strobe in the same cycle
    if (stop_det) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      ack_hi_d = 1'b0;
    end else if (start_det) begin
      state_d  = ST_ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      ack_hi_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_REG, ST_WDATA: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 3'd1;
            if (last_bit) begin
              if (state_q == ST_ADDR) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  state_d = ST_ACK_ADDR;
                  rw_d    = rx_byte[RW_BIT];
                  busy_d  = 1'b1;
                end else begin
                  state_d = ST_IGNORE;
                end
              end else if (state_q == ST_REG) begin
                ptr_d   = rx_byte[IDX_W-1:0];
                state_d = ST_ACK_REG;
              end else begin
                reg_we     = 1'b1;
                wr_valid_d = 1'b1;
                wr_addr_d  = ptr8;
                wr_data_d  = rx_byte;
                ptr_d      = ptr_q + IDX_W'(1);
                state_d    = ST_ACK_W;
              end
            end
          end
        end
        ST_ACK_ADDR, ST_ACK_REG, ST_ACK_W: begin
          if (scl_fall) begin
            if (!ack_hi_q) begin
              sda_oe_d = 1'b1;
              ack_hi_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              ack_hi_d = 1'b0;
              if (state_q == ST_ACK_ADDR && rw_q) begin
                // Read: the ACK-ending fall is also the slot for data bit 7
                state_d  = ST_RDATA;
                sda_oe_d = ~rd_byte[7];
                shift_d  = {rd_byte[6:0], 1'b0};
              end else if (state_q == ST_ACK_ADDR) begin
                state_d = ST_REG;
              end else begin
                state_d = ST_WDATA;
              end
            end
          end
        end
        ST_RDATA: begin
          if (scl_fall) begin
            sda_oe_d = ~shift_q[7];
            shift_d  = {shift_q[6:0], 1'b0};
          end else if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (last_bit) begin
              state_d = ST_ACK_R;
              ptr_d   = ptr_q + IDX_W'(1);
            end
          end
        end
        ST_ACK_R: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            if (sda_s == I2C_ACK) begin
              state_d = ST_RDATA;
              shift_d = rd_byte;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      rw_q       <= 1'b0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      ack_hi_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      ack_hi_q   <= ack_hi_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      dbg_data_q <= '0;
    end else begin
      if (reg_we) begin
        regs_q[ptr_q] <= rx_byte;
      end
      dbg_data_q <= regs_q[dbg_addr[IDX_W-1:0]];
    end
  end

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign dbg_data = dbg_data_q;

endmodule

// File: doc/i2c_reg_responder.md
# i2c_reg_responder

Single-clock I2C target (responder) that answers the DVI-transmitter configuration master on the SCL/SDA pair and holds a byte-wide register file mirroring the transmitter's configuration space. Sits on the same bidirectional I2C bus as the configuration master. Used in simulation and loopback builds to capture and check the configuration sequence, and as a reusable register slave for later boards. SCL/SDA are oversampled on `clk`; the block drives SDA open-drain only, never SCL (no clock stretching).

## Interface
- `DEV_ADDR`, default 7'h76: 7-bit target address; the block responds only to this address.
- `REG_DEPTH`, default 256: number of 8-bit registers; power of two, ≤256.
- `clk`  in  1: system clock, ≥8× SCL rate.
- `rst`  in  1: synchronous, active-high reset.
- `scl_in`  in  1: raw SCL pin level (asynchronous).
- `sda_in`  in  1: raw SDA pin level (asynchronous).
- `sda_oe`  out  1: 1 pulls SDA low; the top level converts this to tri-state (0 means release/'z').
- `busy`  out  1: high from START with matching address until STOP.
- `wr_valid`  out  1: one-cycle pulse per register byte written by the master.
- `wr_addr`  out  8: register index of the `wr_valid` write.
- `wr_data`  out  8: data of the `wr_valid` write.
- `dbg_addr`  in  8: host-side read index.
- `dbg_data`  out  8: registered contents of `dbg_addr`, one-cycle latency.

## Operation
- Input conditioning: 2-FF synchronizer on each pin, then a third register for edge detection. `scl_rise`, `scl_fall`, `start` (SDA fall while SCL high) and `stop` (SDA rise while SCL high) are one-cycle strobes.
- FSM states: IDLE, ADDR, ACK_ADDR, REG, ACK_REG, WDATA, ACK_W, RDATA, ACK_R, IGNORE.
- `start` in any state → ADDR, bit counter cleared. This covers repeated START.
- `stop` in any state → IDLE, `sda_oe`=0, `busy`=0.
- Bits are sampled on `scl_rise`, MSB first, into an 8-bit shift register; counter 0..7.
- ADDR, after 8 bits:
  - address match → ACK_ADDR with R/W latched;
  - mismatch → IGNORE until START/STOP.
- ACK_ADDR, ACK_REG, ACK_W: assert `sda_oe` on the `scl_fall` that follows the 8th bit; release on the next `scl_fall`. Next state after the ACK slot:
  - after ACK_ADDR: write → REG, read → RDATA;
  - after ACK_REG and ACK_W → WDATA.
- REG: byte loads the register pointer (`ptr`).
- WDATA: byte is written to `regs[ptr]`; `wr_valid` pulses in the cycle after the 8th `scl_rise`, with `wr_addr`=`ptr`. `ptr` then increments.
- RDATA: on entry, `regs[ptr]` is loaded into the shift register. Each bit is driven on `scl_fall` (`sda_oe` = ~bit). Releases after bit 0. `ptr` increments at the end of the byte.
- ACK_R: sample the master's ACK on `scl_rise`.
  - ACK (SDA low) → RDATA with the next byte;
  - NACK → IGNORE (wait for STOP/START).
- Pointer arithmetic: `ptr` wraps modulo `REG_DEPTH` (index width = log2 `REG_DEPTH`; upper address bits ignored). 255+1 → 0.
- Writes to indices ≥ `REG_DEPTH` alias modulo `REG_DEPTH`.
- Register file reset value: all 0x00.
- Reset values of outputs:
  - `sda_oe`=0, `busy`=0, `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `dbg_data`=0;
  - FSM in IDLE; synchronizers preset to 1 (idle bus).
- Reset mid-transfer: everything returns to the reset state within one cycle and the block re-synchronizes at the next START. It never holds SDA low after `rst`.

## Timing
- Pin-to-strobe latency: 3 `clk` cycles.
- SDA is changed only in the cycle after a detected `scl_fall` (≥3 cycles after the pin edge). This provides hold time; it is never changed while synchronized SCL is high.
- `wr_valid`: 1 cycle after the 8th data `scl_rise` strobe.
- `dbg_data`: `regs[dbg_addr]` as of the previous edge. A same-cycle write is visible one cycle later.
- Simultaneous `start`/`stop` and a bit strobe: START/STOP wins, and the bit is discarded.

## Structure
- Shared package `i2c_pkg`: FSM state enum, `I2C_ACK`=0 / `I2C_NACK`=1 constants, and the R/W bit position.
- One natural sub-module, `i2c_pin_sync`: synchronizer plus edge/START/STOP detector, reused by any future I2C target.
- Register file is an inferred array inside the top module.

## Test plan
- Write burst: START, 0xEC, reg 0x49, data 0xC0, 0x09, STOP →
  - ACK on all 4 bytes;
  - `wr_valid` pulses with (0x49,0xC0) then (0x4A,0x09);
  - `dbg_addr`=0x4A reads 0x09.
- Random read: START 0xEC, reg 0x49, repeated START 0xED, master ACK then NACK →
  - SDA bytes 0xC0, 0x09;
  - `sda_oe`=0 after the NACK; `busy` falls at STOP.
- Wrong address: 0xE0 → no ACK (`sda_oe` stays 0), no `wr_valid`, state IGNORE until STOP.
- Wrap: write from reg 0xFF with data 0x11, 0x22 → `regs[0xFF]`=0x11, `regs[0x00]`=0x22.
- `rst` asserted during an RDATA bit with `sda_oe`=1 → `sda_oe`=0 next cycle. The following full write transaction completes correctly.
- Glitch-free hold: SCL/SDA edges with SCL period = 8 `clk` → every `sda_oe` transition lands ≥3 cycles after the SCL falling pin edge.
